// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - cache miss-fill controller with pipelined, bounded word requests
module cache_fill_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int WORDS      = 8,
    parameter int WORD_BYTES = 2,
    parameter int MAX_OUT    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_detected,
    input  logic [ADDR_W-1:0]        miss_address,
    input  logic                     mem_grant,
    input  logic                     memory_data_valid,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        memory_address,
    output logic                     write_data_array,
    output logic [$clog2(WORDS)-1:0] word_index,
    output logic                     write_tag_array,
    output logic [ADDR_W-1:0]        tag_address,
    output logic                     fsm_busy,
    output logic                     protocol_err
);
    localparam int IDX_W     = $clog2(WORDS);
    localparam int CNT_W     = IDX_W + 1;
    localparam int BLK_BYTES = WORDS * WORD_BYTES;
    localparam int BYTE_SH   = $clog2(WORD_BYTES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_TAG  = 2'd2;

    localparam logic [ADDR_W-1:0] BLK_MASK  = ADDR_W'(BLK_BYTES - 1);
    localparam logic [CNT_W-1:0]  WORDS_C   = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  MAX_OUT_C = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  issue_q, issue_d;
    logic [CNT_W-1:0]  recv_q, recv_d;
    logic              perr_q, perr_d;

    logic [CNT_W-1:0]  outstanding;
    logic              in_fill;
    logic              do_issue;
    logic              do_write;

    always_comb begin
        outstanding      = issue_q - recv_q;
        in_fill          = (state_q == ST_FILL);
        mem_req          = in_fill && (issue_q < WORDS_C) && (outstanding < MAX_OUT_C);
        memory_address   = in_fill ? (base_q | (ADDR_W'(issue_q[IDX_W-1:0]) << BYTE_SH)) : '0;
        do_issue         = mem_req && mem_grant;
        // Returns with nothing in flight are stale or bogus; they never reach the data array.
        do_write         = in_fill && memory_data_valid && (outstanding != '0);
        write_data_array = do_write;
        word_index       = do_write ? recv_q[IDX_W-1:0] : '0;
        write_tag_array  = (state_q == ST_TAG);
        tag_address      = base_q;
        fsm_busy         = (state_q == ST_IDLE) ? miss_detected : 1'b1;
        protocol_err     = perr_q;

        state_d = state_q;
        base_d  = base_q;
        issue_d = issue_q;
        recv_d  = recv_q;
        perr_d  = perr_q;

        case (state_q)
            ST_IDLE: begin
                if (miss_detected) begin
                    base_d  = miss_address & ~BLK_MASK;
                    issue_d = '0;
                    recv_d  = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (do_issue) begin
                    issue_d = issue_q + CNT_ONE;
                end
                if (do_write) begin
                    recv_d = recv_q + CNT_ONE;
                    if (recv_q[IDX_W-1:0] == LAST_IDX) begin
                        state_d = ST_TAG;
                    end
                end
                if (memory_data_valid && (outstanding == '0)) begin
                    perr_d = 1'b1;
                end
            end
            ST_TAG: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            issue_q <= '0;
            recv_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
            perr_q  <= perr_d;
        end
    end

endmodule
